motor_cmd_arbiter: RTL and testbench

MOTOR_CMD_ARBITER -- requirements
Module: motor_cmd_arbiter

---
 rtl/motor_cmd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_motor_cmd_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : motor_cmd_arbiter
// Brief  : Selects OFF / RC / AI / SAFETY motor commands, slew-limits RC/AI
//          outputs and runs a per-source command watchdog.
// Rev    : 1.0
// ============================================================================
module motor_cmd_arbiter #(
    parameter int RAMP_DIV  = 14746,
    parameter int STEP      = 1,
    parameter int WDT_TICKS = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mode,
    input  logic signed [7:0] rcSpeedA,
    input  logic signed [7:0] rcSpeedB,
    input  logic              rcStrobe,
    input  logic signed [7:0] aiSpeedA,
    input  logic signed [7:0] aiSpeedB,
    input  logic              aiStrobe,
    input  logic              safetyReq,
    input  logic signed [7:0] safetySpeed,
    output logic signed [7:0] speedA,
    output logic signed [7:0] speedB,
    output logic              aliveStrobe,
    output logic [1:0]        source,
    output logic              timeout
);

    localparam int C_PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int C_WDT_W = $clog2(WDT_TICKS + 1);
    localparam logic [C_PRE_W-1:0] C_PRE_MAX  = C_PRE_W'(RAMP_DIV - 1);
    localparam logic [C_WDT_W-1:0] C_WDT_LAST = C_WDT_W'(WDT_TICKS - 1);
    localparam logic signed [8:0]  C_STEP     = 9'(STEP);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RC   = 2'd1;
    localparam logic [1:0] S_AI   = 2'd2;
    localparam logic [1:0] S_SAFE = 2'd3;

    logic [1:0]         r_state;
    logic signed [7:0]  r_speed_a, r_speed_b;
    logic               r_alive;
    logic               r_timeout;
    logic signed [7:0]  r_rc_a, r_rc_b, r_ai_a, r_ai_b;
    logic               r_rc_prev, r_ai_prev;
    logic [C_PRE_W-1:0] r_pre;
    logic [C_WDT_W-1:0] r_wdt;

    logic [1:0]         w_state_nxt;
    logic               w_rc_evt, w_ai_evt, w_sel_evt;
    logic               w_tick, w_ramping, w_nxt_ramping;
    logic signed [7:0]  w_tgt_a, w_tgt_b, w_byp;

    // Moves cur toward tgt by at most STEP; 9-bit math so the full
    // -128..+127 span cannot wrap.
    function automatic logic signed [7:0] f_ramp(input logic signed [7:0] cur,
                                                 input logic signed [7:0] tgt);
        logic signed [8:0] diff;
        logic signed [8:0] res;
        diff = {tgt[7], tgt} - {cur[7], cur};
        if (diff > C_STEP)
            res = {cur[7], cur} + C_STEP;
        else if (diff < -C_STEP)
            res = {cur[7], cur} - C_STEP;
        else
            res = {tgt[7], tgt};
        return res[7:0];
    endfunction

    always_comb begin
        w_state_nxt = S_OFF;
        if (safetyReq)
            w_state_nxt = S_SAFE;
        else if (mode == 8'd1)
            w_state_nxt = S_RC;
        else if (mode == 8'd2)
            w_state_nxt = S_AI;
    end

    assign w_rc_evt      = rcStrobe != r_rc_prev;
    assign w_ai_evt      = aiStrobe != r_ai_prev;
    assign w_sel_evt     = ((r_state == S_RC) && w_rc_evt) || ((r_state == S_AI) && w_ai_evt);
    assign w_tick        = r_pre == C_PRE_MAX;
    assign w_ramping     = (r_state == S_RC) || (r_state == S_AI);
    assign w_nxt_ramping = (w_state_nxt == S_RC) || (w_state_nxt == S_AI);
    assign w_byp         = (w_state_nxt == S_SAFE) ? safetySpeed : 8'sd0;

    always_comb begin
        w_tgt_a = 8'sd0;
        w_tgt_b = 8'sd0;
        if (r_state == S_RC && !r_timeout) begin
            w_tgt_a = r_rc_a;
            w_tgt_b = r_rc_b;
        end else if (r_state == S_AI && !r_timeout) begin
            w_tgt_a = r_ai_a;
            w_tgt_b = r_ai_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_OFF;
            r_speed_a <= 8'sd0;
            r_speed_b <= 8'sd0;
            r_alive   <= 1'b0;
            r_timeout <= 1'b0;
            r_rc_a    <= 8'sd0;
            r_rc_b    <= 8'sd0;
            r_ai_a    <= 8'sd0;
            r_ai_b    <= 8'sd0;
            r_rc_prev <= rcStrobe;
            r_ai_prev <= aiStrobe;
            r_pre     <= '0;
            r_wdt     <= '0;
        end else begin
            r_rc_prev <= rcStrobe;
            r_ai_prev <= aiStrobe;
            if (w_rc_evt) begin
                r_rc_a <= rcSpeedA;
                r_rc_b <= rcSpeedB;
            end
            if (w_ai_evt) begin
                r_ai_a <= aiSpeedA;
                r_ai_b <= aiSpeedB;
            end

            r_state <= w_state_nxt;
            r_pre   <= w_tick ? '0 : r_pre + C_PRE_W'(1);

            // SAFETY/OFF follow the next state directly so the override lands
            // in the same cycle the source output changes.
            if (!w_nxt_ramping) begin
                r_speed_a <= w_byp;
                r_speed_b <= w_byp;
            end else if (w_ramping && w_tick) begin
                r_speed_a <= f_ramp(r_speed_a, w_tgt_a);
                r_speed_b <= f_ramp(r_speed_b, w_tgt_b);
            end

            if (!w_nxt_ramping || (w_state_nxt != r_state) || w_sel_evt) begin
                r_wdt     <= '0;
                r_timeout <= 1'b0;
            end else if (w_tick && !r_timeout) begin
                if (r_wdt == C_WDT_LAST)
                    r_timeout <= 1'b1;
                else
                    r_wdt <= r_wdt + C_WDT_W'(1);
            end

            if (w_tick && ((r_state == S_SAFE) ||
                           (w_ramping && (!r_timeout || r_speed_a != 8'sd0 || r_speed_b != 8'sd0))))
                r_alive <= ~r_alive;
        end
    end

    assign speedA      = r_speed_a;
    assign speedB      = r_speed_b;
    assign aliveStrobe = r_alive;
    assign source      = r_state;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_motor_cmd_arbiter
// Brief  : Directed self-checking bench for motor_cmd_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_motor_cmd_arbiter;

    localparam int RAMP_DIV  = 4;
    localparam int STEP      = 8;
    localparam int WDT_TICKS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        mode;
    logic signed [7:0] rcSpeedA, rcSpeedB, aiSpeedA, aiSpeedB, safetySpeed;
    logic              rcStrobe, aiStrobe, safetyReq;
    logic signed [7:0] speedA, speedB;
    logic              aliveStrobe;
    logic [1:0]        source;
    logic              timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_pre;

    motor_cmd_arbiter #(
        .RAMP_DIV (RAMP_DIV),
        .STEP     (STEP),
        .WDT_TICKS(WDT_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .rcSpeedA   (rcSpeedA),
        .rcSpeedB   (rcSpeedB),
        .rcStrobe   (rcStrobe),
        .aiSpeedA   (aiSpeedA),
        .aiSpeedB   (aiSpeedB),
        .aiStrobe   (aiStrobe),
        .safetyReq  (safetyReq),
        .safetySpeed(safetySpeed),
        .speedA     (speedA),
        .speedB     (speedB),
        .aliveStrobe(aliveStrobe),
        .source     (source),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference prescaler: tells the bench which edge carries a ramp tick.
    always @(posedge clk) begin
        if (rst)
            tb_pre <= 0;
        else
            tb_pre <= (tb_pre == RAMP_DIV - 1) ? 0 : tb_pre + 1;
    end

    // Advance to just after the next tick edge, optionally refreshing a strobe
    // on the first (non-tick) falling edge.
    task automatic next_tick(input bit feed_rc, input bit feed_ai);
        int n = 0;
        @(negedge clk);
        if (feed_rc) rcStrobe = ~rcStrobe;
        if (feed_ai) aiStrobe = ~aiStrobe;
        while (tb_pre != RAMP_DIV - 1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            n_bad++;
            $display("FAIL tick_wait got no tick within %0d cycles", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 8'd0; safetyReq = 1'b0; safetySpeed = 8'sd0;
        rcSpeedA = 8'sd0; rcSpeedB = 8'sd0; aiSpeedA = 8'sd0; aiSpeedB = 8'sd0;
        rcStrobe = 1'b1; aiStrobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({speedA, speedB, source, timeout, aliveStrobe} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_state got A=%0d B=%0d src=%0d to=%0b alive=%0b want all 0",
                     speedA, speedB, source, timeout, aliveStrobe);
        end
        @(negedge clk) rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({speedA, speedB, source, timeout, aliveStrobe} !== 19'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle got A=%0d B=%0d src=%0d to=%0b alive=%0b want all 0",
                     speedA, speedB, source, timeout, aliveStrobe);
        end
    endtask

    task automatic test_rc_ramp();
        logic signed [7:0] ea, eb;
        @(negedge clk);
        mode = 8'd1; rcSpeedA = 8'sd40; rcSpeedB = -8'sd20; rcStrobe = ~rcStrobe;
        @(posedge clk);
        #1;
        n_cmp++;
        if (source !== 2'd1) begin
            n_bad++;
            $display("FAIL rc_source got %0d want 1", source);
        end
        for (int k = 1; k <= 5; k++) begin
            next_tick(1'b1, 1'b0);
            ea = 8'(8 * k);
            eb = (k < 3) ? 8'(-8 * k) : -8'sd20;
            n_cmp++;
            if (speedA !== ea || speedB !== eb) begin
                n_bad++;
                $display("FAIL rc_ramp_up[%0d] got A=%0d B=%0d want A=%0d B=%0d", k, speedA, speedB, ea, eb);
            end
        end
    endtask

    task automatic test_rc_reverse();
        logic signed [7:0] ea;
        rcSpeedA = -8'sd40;
        for (int k = 1; k <= 10; k++) begin
            next_tick(1'b1, 1'b0);
            ea = 8'(40 - 8 * k);
            n_cmp++;
            if (speedA !== ea || speedB !== -8'sd20) begin
                n_bad++;
                $display("FAIL rc_reverse[%0d] got A=%0d B=%0d want A=%0d B=-20", k, speedA, speedB, ea);
            end
        end
    endtask

    task automatic test_watchdog();
        logic signed [7:0] exp_a [5] = '{-8'sd32, -8'sd24, -8'sd16, -8'sd8, 8'sd0};
        logic signed [7:0] exp_b [5] = '{-8'sd12, -8'sd4, 8'sd0, 8'sd0, 8'sd0};
        logic al;
        next_tick(1'b0, 1'b0);
        n_cmp++;
        if (timeout !== 1'b0 || speedA !== -8'sd40 || speedB !== -8'sd20) begin
            n_bad++;
            $display("FAIL wdt_tick2 got to=%0b A=%0d B=%0d want to=0 A=-40 B=-20", timeout, speedA, speedB);
        end
        next_tick(1'b0, 1'b0);
        n_cmp++;
        if (timeout !== 1'b1 || speedA !== -8'sd40 || speedB !== -8'sd20) begin
            n_bad++;
            $display("FAIL wdt_expire got to=%0b A=%0d B=%0d want to=1 A=-40 B=-20", timeout, speedA, speedB);
        end
        for (int k = 0; k < 5; k++) begin
            al = aliveStrobe;
            next_tick(1'b0, 1'b0);
            n_cmp++;
            if (speedA !== exp_a[k] || speedB !== exp_b[k] || aliveStrobe !== ~al) begin
                n_bad++;
                $display("FAIL wdt_ramp0[%0d] got A=%0d B=%0d alive=%0b want A=%0d B=%0d alive=%0b",
                         k, speedA, speedB, aliveStrobe, exp_a[k], exp_b[k], ~al);
            end
        end
        al = aliveStrobe;
        for (int k = 0; k < 2; k++) begin
            next_tick(1'b0, 1'b0);
            n_cmp++;
            if (aliveStrobe !== al || speedA !== 8'sd0 || timeout !== 1'b1) begin
                n_bad++;
                $display("FAIL wdt_alive_stop[%0d] got alive=%0b A=%0d to=%0b want alive=%0b A=0 to=1",
                         k, aliveStrobe, speedA, timeout, al);
            end
        end
        next_tick(1'b1, 1'b0);
        n_cmp++;
        if (timeout !== 1'b0 || speedA !== -8'sd8 || speedB !== -8'sd8) begin
            n_bad++;
            $display("FAIL wdt_recover got to=%0b A=%0d B=%0d want to=0 A=-8 B=-8", timeout, speedA, speedB);
        end
    endtask

    task automatic test_safety();
        logic signed [7:0] e;
        @(negedge clk);
        mode = 8'd2; aiSpeedA = 8'sd40; aiSpeedB = 8'sd40; aiStrobe = ~aiStrobe;
        @(posedge clk);
        #1;
        n_cmp++;
        if (source !== 2'd2) begin
            n_bad++;
            $display("FAIL ai_source got %0d want 2", source);
        end
        for (int k = 1; k <= 6; k++) next_tick(1'b0, 1'b1);
        n_cmp++;
        if (speedA !== 8'sd40 || speedB !== 8'sd40) begin
            n_bad++;
            $display("FAIL ai_reach got A=%0d B=%0d want 40/40", speedA, speedB);
        end
        @(negedge clk);
        safetySpeed = 8'shD8; safetyReq = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({speedA, speedB, source, timeout} !== {8'hD8, 8'hD8, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL safety_enter got A=%0h B=%0h src=%0d to=%0b want D8 D8 3 0",
                     speedA, speedB, source, timeout);
        end
        @(negedge clk) safetyReq = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({speedA, speedB, source} !== {8'hD8, 8'hD8, 2'd2}) begin
            n_bad++;
            $display("FAIL safety_release got A=%0h B=%0h src=%0d want D8 D8 2", speedA, speedB, source);
        end
        for (int k = 1; k <= 10; k++) begin
            next_tick(1'b0, 1'b1);
            e = 8'(-40 + 8 * k);
            n_cmp++;
            if (speedA !== e || speedB !== e) begin
                n_bad++;
                $display("FAIL safety_ramp[%0d] got A=%0d B=%0d want %0d", k, speedA, speedB, e);
            end
        end
    endtask

    task automatic test_extremes();
        logic signed [7:0] ea;
        aiSpeedA = 8'sd127; aiSpeedB = 8'sd127;
        for (int k = 1; k <= 11; k++) begin
            next_tick(1'b0, 1'b1);
            ea = (40 + 8 * k > 127) ? 8'sd127 : 8'(40 + 8 * k);
            n_cmp++;
            if (speedA !== ea || speedB !== ea) begin
                n_bad++;
                $display("FAIL ramp_to_max[%0d] got A=%0d B=%0d want %0d", k, speedA, speedB, ea);
            end
        end
        aiSpeedA = -8'sd128;
        for (int k = 1; k <= 33; k++) begin
            next_tick(1'b0, 1'b1);
            ea = (127 - 8 * k < -128) ? -8'sd128 : 8'(127 - 8 * k);
            n_cmp++;
            if (speedA !== ea || speedB !== 8'sd127) begin
                n_bad++;
                $display("FAIL ramp_to_min[%0d] got A=%0d B=%0d want A=%0d B=127", k, speedA, speedB, ea);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic signed [7:0] ea;
        aiSpeedA = 8'sd127;
        for (int k = 1; k <= 3; k++) begin
            next_tick(1'b0, 1'b1);
            ea = 8'(-128 + 8 * k);
            n_cmp++;
            if (speedA !== ea) begin
                n_bad++;
                $display("FAIL mid_ramp[%0d] got A=%0d want %0d", k, speedA, ea);
            end
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({speedA, speedB, source, timeout, aliveStrobe} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_mid_ramp got A=%0d B=%0d src=%0d to=%0b alive=%0b want all 0",
                     speedA, speedB, source, timeout, aliveStrobe);
        end
        @(negedge clk) mode = 8'd5;
        @(negedge clk) rst = 1'b0;
        next_tick(1'b0, 1'b0);
        next_tick(1'b0, 1'b1);
        n_cmp++;
        if ({speedA, speedB, source, timeout, aliveStrobe} !== 19'd0) begin
            n_bad++;
            $display("FAIL invalid_mode_off got A=%0d B=%0d src=%0d to=%0b alive=%0b want all 0",
                     speedA, speedB, source, timeout, aliveStrobe);
        end
    endtask

    initial begin
        test_reset();
        test_rc_ramp();
        test_rc_reverse();
        test_watchdog();
        test_safety();
        test_extremes();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
